// File: rtl/shared_reg_arb_pkg.sv
// Shared types and width helpers for the round-robin shared-register arbiter.
package shared_reg_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 15;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W = idx_width(N_REQ_DEF);
  localparam int WD_W = idx_width(TIMEOUT_DEF + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/shared_reg_arbiter_pick.sv
// Combinational round-robin pick: first set req bit searching upward from ptr+1,
// wrapping modulo N_REQ (also correct when N_REQ is not a power of two).
module rr_priority_pick
  import shared_reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);

  logic [ID_W:0] cand;

  // Walk from the lowest priority offset to the highest so the last hit wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(N_REQ)) begin
        cand = cand - (ID_W + 1)'(N_REQ);
      end
      if (req[cand[ID_W-1:0]]) begin
        winner = cand[ID_W-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register, with a
// watchdog that revokes grants held too long in RELEASE.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter  int N_REQ   = N_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int IDW     = idx_width(N_REQ),
  localparam int WDW     = idx_width(TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   wr_data,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         q,
  output logic [IDW-1:0]            owner,
  output logic                      busy,
  output logic                      err,
  output arb_state_e                dbg_state
);

  // Handshake: a requester holds req high; gnt marks ownership, ack pulses once
  // when its data has landed in q, and ownership ends when req falls (or on revoke).

  arb_state_e        state, state_nx;
  logic [IDW-1:0]    ptr, ptr_d, owner_d, pick_idx;
  logic              pick_vld;
  logic [WDW-1:0]    wdog, wdog_d;
  logic [N_REQ-1:0]  gnt_d, ack_d;
  logic [DATA_W-1:0] q_d, owner_data;
  logic              busy_d, err_d, owner_req, wdog_hit;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .ID_W  (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  assign owner_req  = req[owner];
  assign owner_data = wr_data[owner*DATA_W +: DATA_W];
  assign wdog_hit   = (wdog == WDW'(TIMEOUT - 1));
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = GRANT;
      GRANT:   state_nx = ACK;
      ACK:     state_nx = RELEASE;
      RELEASE: if (!owner_req || wdog_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt;
    ack_d   = '0;
    q_d     = q;
    owner_d = owner;
    busy_d  = busy;
    err_d   = 1'b0;
    ptr_d   = ptr;
    wdog_d  = wdog;
    case (state)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_vld) begin
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          busy_d          = 1'b1;
        end
      end
      GRANT: begin
        q_d        = owner_data;
        ack_d[owner] = 1'b1;
      end
      ACK: begin
        wdog_d = '0;
      end
      RELEASE: begin
        if (!owner_req) begin
          gnt_d  = '0;
          busy_d = 1'b0;
          ptr_d  = owner;
        end else if (wdog_hit) begin
          // Revoked owner goes to the back of the rotation like a normal release.
          gnt_d  = '0;
          busy_d = 1'b0;
          err_d  = 1'b1;
          ptr_d  = owner;
          wdog_d = wdog + 1'b1;
        end else begin
          wdog_d = wdog + 1'b1;
        end
      end
      default: begin
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt   <= '0;
      ack   <= '0;
      q     <= '0;
      owner <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
      ptr   <= IDW'(N_REQ - 1);
      wdog  <= '0;
    end else begin
      gnt   <= gnt_d;
      ack   <= ack_d;
      q     <= q_d;
      owner <= owner_d;
      busy  <= busy_d;
      err   <= err_d;
      ptr   <= ptr_d;
      wdog  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: grant order, write data, ack pulse,
// watchdog revoke and asynchronous reset, with a queue of expected q values.
module tb_shared_reg_arbiter;
  import shared_reg_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] wr_data = '0;
  logic [N-1:0]    gnt, ack;
  logic [DW-1:0]   q;
  logic [1:0]      owner;
  logic            busy, err;
  arb_state_e      dbg_state;

  logic [DW-1:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  shared_reg_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .wr_data   (wr_data),
    .gnt       (gnt),
    .ack       (ack),
    .q         (q),
    .owner     (owner),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slice(input int id, input logic [DW-1:0] v);
    wr_data[id*DW +: DW] = v;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_q"},     32'(q),    32'h0);
    chk({tag, "_gnt"},   32'(gnt),  32'h0);
    chk({tag, "_ack"},   32'(ack),  32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
  endtask

  // Waits (bounded) for a grant, then checks grant, write and ack timing.
  task automatic txn(input int id, input bit drop_early);
    logic [N-1:0] oh;
    logic [DW-1:0] e;
    oh = '0;
    oh[id] = 1'b1;
    for (int i = 0; i < 20 && gnt == '0; i++) tick();
    chk("gnt", 32'(gnt), 32'(oh));
    chk("owner", 32'(owner), 32'(id));
    chk("busy_on", 32'(busy), 32'h1);
    if (drop_early) req[id] = 1'b0;
    tick();
    e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    chk("ack_pulse", 32'(ack), 32'(oh));
    chk("q_data", 32'(q), 32'(e));
    tick();
    chk("ack_end", 32'(ack), 32'h0);
    chk("gnt_hold", 32'(gnt), 32'(oh));
  endtask

  task automatic release_req(input int id);
    req[id] = 1'b0;
    tick();
    chk("rel_gnt", 32'(gnt), 32'h0);
    chk("rel_busy", 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    tick();
    tick();
    chk_idle_outputs("reset");
    chk("reset_owner", 32'(owner), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
  endtask

  initial begin
    // Single requester
    do_reset();
    set_slice(0, 8'hA5);
    req = 4'b0001;
    exp_q.push_back(8'hA5);
    txn(0, 1'b0);
    release_req(0);

    // Contention from reset: 0,1,2,3 then 0 again
    do_reset();
    set_slice(0, 8'h11); set_slice(1, 8'h22); set_slice(2, 8'h33); set_slice(3, 8'h44);
    req = 4'b1111;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    for (int id = 0; id < N; id++) begin
      txn(id, 1'b0);
      release_req(id);
      if (id == 0) begin
        req[0] = 1'b1;
        set_slice(0, 8'h55);
      end
    end
    txn(0, 1'b0);
    release_req(0);

    // Rotation: 2 served last, then 0101 wraps to 0 before 2
    set_slice(2, 8'h66);
    req = 4'b0100;
    exp_q.push_back(8'h66);
    txn(2, 1'b0);
    release_req(2);
    set_slice(0, 8'h77); set_slice(2, 8'h88);
    req = 4'b0101;
    exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    txn(0, 1'b0);
    release_req(0);
    txn(2, 1'b0);
    release_req(2);

    // Watchdog: requester 1 holds forever, 3 waits
    set_slice(1, 8'h99);
    req = 4'b0010;
    exp_q.push_back(8'h99);
    txn(1, 1'b0);
    req[3] = 1'b1;
    set_slice(3, 8'hC3);
    exp_q.push_back(8'hC3);
    for (int c = 1; c < TO; c++) begin
      tick();
      chk("wd_err_low", 32'(err), 32'h0);
      chk("wd_gnt_held", 32'(gnt), 32'h2);
    end
    tick();
    chk("wd_err", 32'(err), 32'h1);
    chk("wd_gnt_drop", 32'(gnt), 32'h0);
    chk("wd_busy", 32'(busy), 32'h0);
    tick();
    chk("wd_err_pulse", 32'(err), 32'h0);
    txn(3, 1'b0);
    req[1] = 1'b0;
    release_req(3);

    // Asynchronous reset in the middle of ACK
    set_slice(0, 8'h5A);
    req = 4'b0001;
    tick();
    chk("ar_gnt", 32'(gnt), 32'h1);
    tick();
    chk("ar_ack", 32'(ack), 32'h1);
    chk("ar_q", 32'(q), 32'h5A);
    #2;
    rst = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    tick();
    set_slice(0, 8'hE1);
    req = 4'b1001;
    exp_q.push_back(8'hE1);
    rst = 1'b1;
    txn(0, 1'b0);
    req[3] = 1'b0;
    release_req(0);

    // Owner drops req during GRANT: write and ack still happen
    set_slice(2, 8'hD2);
    req = 4'b0100;
    exp_q.push_back(8'hD2);
    txn(2, 1'b1);
    release_req(2);
    tick();
    chk("early_idle_gnt", 32'(gnt), 32'h0);
    chk("early_idle_state", 32'(dbg_state), 32'(IDLE));

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared DATA_W-bit D-register bank.
- Up to N_REQ requesters compete for write access with a req/gnt/ack handshake.
- The granted requester's data is loaded into the bank. The current value is output on q, along with the owner ID.
- A watchdog forcibly revokes a grant that is held too long.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, width of the shared register and of each write-data slice
- TIMEOUT, 15, max cycles a grant may be held in RELEASE before forced revoke (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  N_REQ  request lines, level, one per requester
- wr_data  in  N_REQ*DATA_W  write data; slice i = bits [i*DATA_W +: DATA_W]
- gnt  out  N_REQ  one-hot grant, registered
- ack  out  N_REQ  one-cycle write-done pulse to the owner, registered
- q  out  DATA_W  shared register contents
- owner  out  clog2(N_REQ)  index of the current or last granted requester
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on watchdog revoke

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE.
  - q=0, gnt=0, ack=0, owner=0, busy=0, err=0.
  - ptr=N_REQ-1, so requester 0 has first priority.
  - wdog=0.
- Deasserting rst takes effect at the next clk edge. Reset mid-transaction abandons the transaction; q returns to 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, GRANT, ACK, RELEASE.
- IDLE:
  - If req is nonzero at edge E0, the winner is the first set bit searching from ptr+1 upward, with wrap-around modulo N_REQ.
  - After E0: gnt[winner]=1, owner=winner, busy=1, state=GRANT.
  - If req=0, remain in IDLE.
- GRANT: at edge E1, q <= wr_data slice[owner] and state=ACK. q is visible after E1. Latency from req sampled to q updated is 2 edges.
- ACK:
  - ack[owner]=1 for exactly the cycle between E1 and E2.
  - At E2: ack=0, wdog=0, state=RELEASE.
- RELEASE:
  - gnt stays held while req[owner]=1. wdog increments each cycle.
  - If req[owner]=0 at an edge: gnt=0, busy=0, ptr=owner, state=IDLE.
  - If wdog reaches TIMEOUT with req[owner] still 1: gnt=0, err=1 for one cycle, ptr=owner, state=IDLE.
  - After a watchdog revoke, that requester is arbitrated normally again. A still-high req rejoins the round-robin with the lowest priority.
- A new arbitration is only made from IDLE. At least 1 idle cycle separates consecutive grants. Minimum period per transaction is 4 cycles.
- If the owner drops req during GRANT or ACK, the write and ack still complete. RELEASE then exits on its first edge.
- Simultaneous requests: exactly one winner, chosen by round-robin. Losers keep req high and are served in rotation order. Starvation-free: every persistent requester is granted within N_REQ transactions.
- Non-owner req changes never affect q, gnt or ack.
- owner holds its last value in IDLE.
- Widths:
  - wdog is clog2(TIMEOUT+1) bits.
  - ptr and owner are clog2(N_REQ) bits.
  - Wrap-around is modulo N_REQ, including when N_REQ is not a power of 2.

Decomposition:
- Package shared_reg_arb_pkg holds:
  - the state enum (IDLE, GRANT, ACK, RELEASE);
  - localparam ID_W = clog2(N_REQ);
  - localparam WD_W = clog2(TIMEOUT+1).
- One sub-module, rr_priority_pick:
  - combinational, N_REQ-wide;
  - inputs req and ptr;
  - outputs winner index and a valid flag.
- The shared register bank stays inline as a DATA_W-wide flip-flop with load enable.

Test Plan:
- Single requester: reset, then req=4'b0001 with slice0=8'hA5.
  - Required: gnt=0001 one edge later.
  - Required: q=A5 two edges after req is sampled, and ack[0] pulses for exactly 1 cycle.
  - Drop req: gnt=0 and busy=0 on the next edge.
- Contention: all four req held high, each dropping req one cycle after its ack.
  - Required: grant order 0,1,2,3,0.
  - Required: q follows each requester's slice value in that order.
- Rotation: requester 2 is last served, then req=4'b0101 applied.
  - Required: requester 0 wins (search from 3 wraps to 0).
  - Required: next grant goes to 2.
- Watchdog: TIMEOUT=15, requester 1 never drops req.
  - Required: err pulses for 1 cycle exactly 15 cycles after entering RELEASE, and gnt falls in the same cycle.
  - Required: requester 3, already waiting, is granted next.
- Async reset: assert rst low mid-ACK, between clock edges.
  - Required: q=0, gnt=0, ack=0 immediately, without waiting for a clock edge.
  - Required after release: requester 0 has first priority.
- Early drop: owner drops req during GRANT.
  - Required: write to q and ack still occur, then IDLE follows.
